// File: rtl/histeq_pkg.sv
// Shared definitions for the luma (and future chroma) histogram equalisers:
// FSM state encoding and the saturating arithmetic helpers.
package histeq_pkg;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_IDLE  = 2'd1,
    ST_ACCUM = 2'd2,
    ST_CDF   = 2'd3
  } hist_state_e;

  function automatic logic [31:0] sat_add(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic [31:0] max_v);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s > {1'b0, max_v}) ? max_v : s[31:0];
  endfunction

  // Shift a CDF product down to pixel range and clamp at the top code.
  function automatic logic [31:0] sat_scale(input logic [63:0] prod,
                                            input int          shift,
                                            input logic [31:0] max_v);
    logic [63:0] q;
    q = prod >> shift;
    return (q > {32'd0, max_v}) ? max_v : q[31:0];
  endfunction

endpackage

// File: rtl/histeq_dpram.sv
// Simple dual-port RAM: one synchronous write port, one synchronous read port
// (read returns the contents before a same-cycle write).
module histeq_dpram #(
  parameter int ADDR_W = 8,
  parameter int WIDTH  = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);
  localparam int DEPTH = 2 ** ADDR_W;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
    rdata_q <= mem_q[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/histeq_stream.sv
// Streaming histogram equaliser: bins frame N in RAM, builds its CDF LUT into the
// idle bank, and remaps frame N+1 through the published bank.
module histeq_stream
  import histeq_pkg::*;
#(
  parameter int PIX_W       = 8,
  parameter int CNT_W       = 19,
  parameter int MUL_W       = 6,
  parameter int SCALE_MUL   = 54,
  parameter int SCALE_SHIFT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             frame_start,
  input  logic             frame_end,
  input  logic             in_valid,
  input  logic [PIX_W-1:0] in_y,
  input  logic             map_valid,
  input  logic [PIX_W-1:0] map_y,
  output logic             out_valid,
  output logic [PIX_W-1:0] out_y,
  output logic             busy,
  output logic             lut_ready,
  output logic             overrun
);
  localparam int NBINS = 2 ** PIX_W;
  localparam int PW    = CNT_W + MUL_W;
  localparam int CW    = PIX_W + 2;
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [PIX_W-1:0] PIX_MAX   = '1;
  localparam logic [MUL_W-1:0] MUL_C     = MUL_W'(SCALE_MUL);
  localparam logic [CW-1:0]    INIT_LAST = CW'(NBINS - 1);
  localparam logic [CW-1:0]    CDF_READS = CW'(NBINS);
  localparam logic [CW-1:0]    CDF_LAST  = CW'(NBINS + 2);

  hist_state_e      state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             bank_q, bank_d, lut_ready_q, lut_ready_d, overrun_q, overrun_d;
  logic [CNT_W-1:0] sum_q, sum_d;
  logic             vld_p1_q, vld_p1_d, cdf_p1_q, cdf_p1_d;
  logic [PIX_W-1:0] addr_p1_q, addr_p1_d;
  logic             wr_vld_q, wr_vld_d;
  logic [PIX_W-1:0] wr_addr_q, wr_addr_d;
  logic [CNT_W-1:0] wr_data_q, wr_data_d;
  logic             lut_vld_p2_q, lut_vld_p2_d;
  logic [PIX_W-1:0] lut_addr_p2_q, lut_addr_p2_d, lut_val_p2_q, lut_val_p2_d;
  logic             map_vld_p1_q, map_vld_p1_d, map_bank_p1_q, map_bank_p1_d;
  logic             map_rdy_p1_q, map_rdy_p1_d;
  logic [PIX_W-1:0] map_y_p1_q, map_y_p1_d;
  logic             out_valid_q, out_valid_d;
  logic [PIX_W-1:0] out_y_q, out_y_d;

  logic             inc_go, cdf_go, bin_we;
  logic [PIX_W-1:0] bin_raddr, bin_waddr, lut_rdata0, lut_rdata1;
  logic [CNT_W-1:0] bin_rdata, bin_wdata, bin_old, bin_new, sum_acc;
  logic [PW-1:0]    prod;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bank_d      = bank_q;
    lut_ready_d = lut_ready_q;
    overrun_d   = overrun_q | (frame_start && state_q != ST_IDLE);
    sum_d       = sum_q;

    // p0: issue bin read for an increment or a CDF step
    inc_go    = in_valid && ((state_q == ST_IDLE && frame_start) || state_q == ST_ACCUM);
    cdf_go    = (state_q == ST_CDF) && (cnt_q < CDF_READS);
    bin_raddr = cdf_go ? cnt_q[PIX_W-1:0] : in_y;
    vld_p1_d  = inc_go || cdf_go;
    cdf_p1_d  = cdf_go;
    addr_p1_d = bin_raddr;

    // p1: forward the write still landing in RAM, then increment or clear
    bin_old   = (wr_vld_q && wr_addr_q == addr_p1_q) ? wr_data_q : bin_rdata;
    bin_new   = cdf_p1_q ? '0 : CNT_W'(sat_add(32'(bin_old), 32'd1, 32'(CNT_MAX)));
    wr_vld_d  = vld_p1_q;
    wr_addr_d = addr_p1_q;
    wr_data_d = bin_new;
    sum_acc   = CNT_W'(sat_add(32'(sum_q), 32'(bin_old), 32'(CNT_MAX)));
    prod      = PW'(sum_acc) * PW'(MUL_C);
    lut_vld_p2_d  = vld_p1_q && cdf_p1_q;
    lut_addr_p2_d = addr_p1_q;
    lut_val_p2_d  = PIX_W'(sat_scale(64'(prod), SCALE_SHIFT, 32'(PIX_MAX)));
    if (vld_p1_q && cdf_p1_q) sum_d = sum_acc;

    if (state_q == ST_INIT) begin
      bin_we    = 1'b1;
      bin_waddr = cnt_q[PIX_W-1:0];
      bin_wdata = '0;
    end else begin
      bin_we    = vld_p1_q;
      bin_waddr = addr_p1_q;
      bin_wdata = bin_new;
    end

    case (state_q)
      ST_INIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == INIT_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
      ST_IDLE:  if (frame_start) state_d = ST_ACCUM;
      ST_ACCUM: if (frame_end) begin
        state_d = ST_CDF;
        cnt_d   = '0;
      end
      ST_CDF: begin
        cnt_d = cnt_q + 1'b1;
        // last LUT write has landed: publish the freshly built bank
        if (cnt_q == CDF_LAST) begin
          state_d     = ST_IDLE;
          cnt_d       = '0;
          bank_d      = ~bank_q;
          lut_ready_d = 1'b1;
          sum_d       = '0;
        end
      end
      default: state_d = ST_INIT;
    endcase

    // map p1: bank and ready captured with the read so in-flight pixels finish on it
    map_vld_p1_d  = map_valid;
    map_y_p1_d    = map_y;
    map_bank_p1_d = bank_q;
    map_rdy_p1_d  = lut_ready_q;
    out_valid_d   = map_vld_p1_q;
    out_y_d       = !map_rdy_p1_q ? map_y_p1_q : (map_bank_p1_q ? lut_rdata1 : lut_rdata0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_INIT;
      cnt_q        <= '0;
      bank_q       <= 1'b0;
      lut_ready_q  <= 1'b0;
      overrun_q    <= 1'b0;
      sum_q        <= '0;
      vld_p1_q     <= 1'b0;
      wr_vld_q     <= 1'b0;
      lut_vld_p2_q <= 1'b0;
      map_vld_p1_q <= 1'b0;
      map_rdy_p1_q <= 1'b0;
      out_valid_q  <= 1'b0;
      out_y_q      <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bank_q       <= bank_d;
      lut_ready_q  <= lut_ready_d;
      overrun_q    <= overrun_d;
      sum_q        <= sum_d;
      vld_p1_q     <= vld_p1_d;
      wr_vld_q     <= wr_vld_d;
      lut_vld_p2_q <= lut_vld_p2_d;
      map_vld_p1_q <= map_vld_p1_d;
      map_rdy_p1_q <= map_rdy_p1_d;
      out_valid_q  <= out_valid_d;
      out_y_q      <= out_y_d;
    end
  end

  always_ff @(posedge clk) begin
    cdf_p1_q      <= cdf_p1_d;
    addr_p1_q     <= addr_p1_d;
    wr_addr_q     <= wr_addr_d;
    wr_data_q     <= wr_data_d;
    lut_addr_p2_q <= lut_addr_p2_d;
    lut_val_p2_q  <= lut_val_p2_d;
    map_y_p1_q    <= map_y_p1_d;
    map_bank_p1_q <= map_bank_p1_d;
  end

  histeq_dpram #(.ADDR_W(PIX_W), .WIDTH(CNT_W)) u_bins (
    .clk(clk), .we(bin_we), .waddr(bin_waddr), .wdata(bin_wdata),
    .raddr(bin_raddr), .rdata(bin_rdata)
  );

  // the bank not selected by bank_q is the one being rebuilt
  histeq_dpram #(.ADDR_W(PIX_W), .WIDTH(PIX_W)) u_lut0 (
    .clk(clk), .we(lut_vld_p2_q && bank_q), .waddr(lut_addr_p2_q), .wdata(lut_val_p2_q),
    .raddr(map_y), .rdata(lut_rdata0)
  );

  histeq_dpram #(.ADDR_W(PIX_W), .WIDTH(PIX_W)) u_lut1 (
    .clk(clk), .we(lut_vld_p2_q && !bank_q), .waddr(lut_addr_p2_q), .wdata(lut_val_p2_q),
    .raddr(map_y), .rdata(lut_rdata1)
  );

  assign out_valid = out_valid_q;
  assign out_y     = out_y_q;
  assign busy      = (state_q == ST_INIT) || (state_q == ST_CDF);
  assign lut_ready = lut_ready_q;
  assign overrun   = overrun_q;

endmodule
